// File: rtl/corr_tx_sched.sv
// Frame scheduler: latches a snapshot of all correlator channels and streams a
// header plus each enabled channel word to the word transmitter via start/done.
module corr_tx_sched #(
    parameter int N_CH       = 4,
    parameter int RESOLUTION = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       snap,
    input  logic [N_CH*RESOLUTION-1:0] ch_data,
    input  logic [N_CH-1:0]            ch_mask,
    output logic [RESOLUTION-1:0]      word_data,
    output logic                       word_start,
    input  logic                       word_done,
    output logic                       busy,
    output logic                       frame_done,
    output logic [15:0]                frame_cnt,
    output logic [7:0]                 overrun_cnt
);

    localparam int CNT_W = RESOLUTION - 8;

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t                      state_q, state_d;
    logic [N_CH*RESOLUTION-1:0]  snap_data_q, snap_data_d;
    logic [N_CH-1:0]             pend_q, pend_d;
    logic [RESOLUTION-1:0]       word_data_q, word_data_d;
    logic                        word_start_q, word_start_d;
    logic                        busy_q, busy_d;
    logic                        frame_done_q, frame_done_d;
    logic [15:0]                 frame_cnt_q, frame_cnt_d;
    logic [7:0]                  overrun_q, overrun_d;

    logic [RESOLUTION-1:0]       header;
    logic [N_CH-1:0]             low_bit;
    logic [RESOLUTION-1:0]       nxt_word;

    // Size cast zero-extends the counter for wide words and truncates for narrow ones.
    assign header  = {8'hA5, CNT_W'(frame_cnt_q)};

    // pend_q holds channels not yet sent; its lowest set bit is the next channel.
    assign low_bit = pend_q & (~pend_q + N_CH'(1));

    always_comb begin
        nxt_word = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (low_bit[i]) begin
                nxt_word = snap_data_q[i*RESOLUTION +: RESOLUTION];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        snap_data_d  = snap_data_q;
        pend_d       = pend_q;
        word_data_d  = word_data_q;
        word_start_d = 1'b0;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        overrun_d    = overrun_q;

        case (state_q)
            IDLE: begin
                if (snap) begin
                    snap_data_d  = ch_data;
                    pend_d       = ch_mask;
                    word_data_d  = header;
                    frame_cnt_d  = frame_cnt_q + 16'd1;
                    busy_d       = 1'b1;
                    word_start_d = 1'b1;
                    state_d      = START;
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (word_done) begin
                    if (|pend_q) begin
                        word_data_d  = nxt_word;
                        pend_d       = pend_q & ~low_bit;
                        word_start_d = 1'b1;
                        state_d      = START;
                    end else begin
                        busy_d       = 1'b0;
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Any snapshot outside IDLE is dropped, including on the final word_done edge.
        if (snap && (state_q != IDLE) && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            snap_data_q  <= '0;
            pend_q       <= '0;
            word_data_q  <= '0;
            word_start_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            overrun_q    <= '0;
        end else begin
            state_q      <= state_d;
            snap_data_q  <= snap_data_d;
            pend_q       <= pend_d;
            word_data_q  <= word_data_d;
            word_start_q <= word_start_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            overrun_q    <= overrun_d;
        end
    end

    assign word_data   = word_data_q;
    assign word_start  = word_start_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign frame_cnt   = frame_cnt_q;
    assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_corr_tx_sched.sv
// Bench for corr_tx_sched: a queue-based frame model checked every cycle, a
// transmitter responder with programmable latency, and directed frame scenarios.
module tb_corr_tx_sched;

    localparam int N_CH = 4;
    localparam int RES  = 32;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  snap = 1'b0;
    logic [N_CH*RES-1:0]   ch_data = '0;
    logic [N_CH-1:0]       ch_mask = '0;
    logic [RES-1:0]        word_data;
    logic                  word_start;
    logic                  word_done = 1'b0;
    logic                  busy;
    logic                  frame_done;
    logic [15:0]           frame_cnt;
    logic [7:0]            overrun_cnt;

    always #5 clk = ~clk;

    corr_tx_sched #(.N_CH(N_CH), .RESOLUTION(RES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .snap       (snap),
        .ch_data    (ch_data),
        .ch_mask    (ch_mask),
        .word_data  (word_data),
        .word_start (word_start),
        .word_done  (word_done),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .overrun_cnt(overrun_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: a frame is a queue of words built at acceptance time.
    logic              m_busy = 1'b0;
    logic              m_start = 1'b0;
    logic              m_fd = 1'b0;
    logic [31:0]       m_word = '0;
    logic [15:0]       m_fcnt = '0;
    logic [7:0]        m_ovr = '0;
    logic [31:0]       m_q[$];
    logic [31:0]       log_q[$];
    int                fd_seen = 0;

    initial begin : model_cmp
        logic nstart, nfd;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_busy = 1'b0; m_start = 1'b0; m_fd = 1'b0;
                m_word = '0; m_fcnt = '0; m_ovr = '0;
                m_q.delete();
            end else begin
                nstart = 1'b0;
                nfd    = 1'b0;
                if (!m_busy) begin
                    if (snap) begin
                        m_q.delete();
                        for (int i = 0; i < N_CH; i++)
                            if (ch_mask[i]) m_q.push_back(ch_data[i*RES +: RES]);
                        m_word = 32'hA500_0000 | {16'h0, m_fcnt};
                        m_fcnt = m_fcnt + 16'd1;
                        m_busy = 1'b1;
                        nstart = 1'b1;
                    end
                end else begin
                    if (snap && m_ovr != 8'hFF) m_ovr = m_ovr + 8'd1;
                    if (!m_start && word_done) begin
                        if (m_q.size() > 0) begin
                            m_word = m_q.pop_front();
                            nstart = 1'b1;
                        end else begin
                            m_busy = 1'b0;
                            nfd    = 1'b1;
                        end
                    end
                end
                m_start = nstart;
                m_fd    = nfd;
            end
            #1;
            chk("word_data",   word_data,   m_word);
            chk("word_start",  word_start,  m_start);
            chk("busy",        busy,        m_busy);
            chk("frame_done",  frame_done,  m_fd);
            chk("frame_cnt",   frame_cnt,   m_fcnt);
            chk("overrun_cnt", overrun_cnt, m_ovr);
            if (word_start) log_q.push_back(word_data);
            if (frame_done) fd_seen++;
        end
    end

    // Transmitter: word_done LAT cycles after each word_start, plus injectable strays.
    int   lat = 20;
    int   tx_cnt = 0;
    logic spur_done = 1'b0;

    initial begin : tx_model
        forever begin
            @(posedge clk);
            #3;
            word_done = spur_done;
            if (!rst_n) tx_cnt = 0;
            else begin
                if (tx_cnt > 0) begin
                    tx_cnt--;
                    if (tx_cnt == 0) word_done = 1'b1;
                end
                if (word_start) tx_cnt = lat;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_snap(input logic [N_CH-1:0] m, input logic [N_CH*RES-1:0] d);
        ch_mask = m;
        ch_data = d;
        snap    = 1'b1;
        tick();
        snap    = 1'b0;
    endtask

    task automatic wait_fd(input int budget);
        int k = 0;
        while (!frame_done && k < budget) begin
            tick();
            k++;
        end
        chk("frame_done_seen", {31'h0, frame_done}, 32'h1);
    endtask

    task automatic wait_words(input int n, input int budget);
        int k = 0;
        while (log_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("words_reached", {31'h0, log_q.size() >= n}, 32'h1);
    endtask

    task automatic chk_log(input int i, input logic [31:0] exp);
        if (i < log_q.size()) chk("log_word", log_q[i], exp);
        else chk("log_len", log_q.size(), i + 1);
    endtask

    task automatic chk_zero_outputs();
        chk("rst_word_data",  word_data,   32'h0);
        chk("rst_word_start", {31'h0, word_start}, 32'h0);
        chk("rst_busy",       {31'h0, busy},       32'h0);
        chk("rst_frame_done", {31'h0, frame_done}, 32'h0);
        chk("rst_frame_cnt",  {16'h0, frame_cnt},  32'h0);
        chk("rst_overrun",    {24'h0, overrun_cnt}, 32'h0);
    endtask

    logic [N_CH*RES-1:0] d1, d2, d3;

    initial begin : driver
        d1 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        d2 = {32'hD0D0D0D0, 32'hC0C0C0C0, 32'hB0B0B0B0, 32'hA0A0A0A0};
        d3 = {32'h0, 32'h0, 32'h0, 32'h5A5A5A5A};
        rst_n = 1'b0;
        repeat (3) tick();
        chk_zero_outputs();
        rst_n = 1'b1;
        tick();

        // Full mask frame
        do_snap(4'b1111, d1);
        wait_fd(400);
        chk("f1_len", log_q.size(), 5);
        chk_log(0, 32'hA5000000);
        chk_log(1, 32'h11111111);
        chk_log(2, 32'h22222222);
        chk_log(3, 32'h33333333);
        chk_log(4, 32'h44444444);
        chk("f1_frame_cnt", {16'h0, frame_cnt}, 32'h1);
        chk("f1_fd_pulses", fd_seen, 1);

        // Sparse mask
        do_snap(4'b1010, d1);
        wait_fd(400);
        chk("f2_len", log_q.size(), 8);
        chk_log(5, 32'hA5000001);
        chk_log(6, 32'h22222222);
        chk_log(7, 32'h44444444);

        // Header-only frame
        do_snap(4'b0000, d1);
        wait_fd(100);
        chk("f3_len", log_q.size(), 9);
        chk_log(8, 32'hA5000002);

        // Overruns mid-frame and on the final word_done edge
        do_snap(4'b1111, d2);
        wait_words(11, 200);
        tick();
        repeat (3) begin
            snap = 1'b1;
            tick();
            snap = 1'b0;
            tick();
            tick();
        end
        ch_data = '1;
        ch_mask = '0;
        begin
            int k = 0;
            while (!(log_q.size() == 14 && tx_cnt == 1) && k < 400) begin
                tick();
                k++;
            end
        end
        ch_mask = 4'b0001;
        ch_data = d3;
        snap    = 1'b1;
        tick();
        chk("ovr_fd_cycle", {31'h0, frame_done}, 32'h1);
        chk("ovr_count", {24'h0, overrun_cnt}, 32'h4);
        tick();
        snap = 1'b0;
        chk("ovr_accept_busy", {31'h0, busy}, 32'h1);
        chk("ovr_accept_cnt", {16'h0, frame_cnt}, 32'h5);
        chk_log(9,  32'hA5000003);
        chk_log(10, 32'hA0A0A0A0);
        chk_log(11, 32'hB0B0B0B0);
        chk_log(12, 32'hC0C0C0C0);
        chk_log(13, 32'hD0D0D0D0);
        wait_fd(200);
        chk("f5_len", log_q.size(), 16);
        chk_log(14, 32'hA5000004);
        chk_log(15, 32'h5A5A5A5A);
        chk("f5_overrun", {24'h0, overrun_cnt}, 32'h4);

        // Stray word_done in IDLE and in START
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        tick();
        chk("spur_idle_busy", {31'h0, busy}, 32'h0);
        chk("spur_idle_len", log_q.size(), 16);
        do_snap(4'b0000, d1);
        chk("spur_start_ws", {31'h0, word_start}, 32'h1);
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        chk("spur_start_busy", {31'h0, busy}, 32'h1);
        chk("spur_start_ws2", {31'h0, word_start}, 32'h0);
        wait_fd(100);
        chk("spur_len", log_q.size(), 17);
        chk_log(16, 32'hA5000005);

        // Reset during the third word's wait
        do_snap(4'b1111, d2);
        wait_words(20, 200);
        tick();
        rst_n = 1'b0;
        #1;
        chk_zero_outputs();
        chk_log(17, 32'hA5000006);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        do_snap(4'b1111, d1);
        wait_fd(400);
        chk("post_rst_len", log_q.size(), 25);
        chk_log(20, 32'hA5000000);
        chk_log(21, 32'h11111111);
        chk_log(22, 32'h22222222);
        chk_log(23, 32'h33333333);
        chk_log(24, 32'h44444444);
        chk("post_rst_cnt", {16'h0, frame_cnt}, 32'h1);

        // Overrun counter saturation under a slow transmitter
        lat = 70;
        do_snap(4'b1111, d1);
        snap = 1'b1;
        repeat (280) tick();
        snap = 1'b0;
        chk("sat_busy", {31'h0, busy}, 32'h1);
        chk("sat_overrun", {24'h0, overrun_cnt}, 32'hFF);
        wait_fd(600);
        lat = 20;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule

// File: doc/corr_tx_sched.md
# corr_tx_sched

Frame scheduler between the correlator accumulators and the UART word transmitter. On a snapshot strobe it latches all channel results plus a channel mask, then feeds a header word followed by each enabled channel word, one at a time, through a start/done handshake to the transmitter. It is the single owner of the word transmitter's data and enable. Snapshots that arrive while a frame is in flight are dropped and counted.

## Interface
- `N_CH`, 4: number of correlator channels, 1..16.
- `RESOLUTION`, 32: word width in bits, ≥16, multiple of 4.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `snap`  in  1  one-cycle snapshot request.
- `ch_data`  in  N_CH*RESOLUTION  channel results; channel i at bits [i*RESOLUTION +: RESOLUTION].
- `ch_mask`  in  N_CH  channel enables; bit i = send channel i.
- `word_data`  out  RESOLUTION  word to transmitter; stable from `word_start` until the matching `word_done`.
- `word_start`  out  1  one-cycle pulse: `word_data` is valid, begin sending.
- `word_done`  in  1  one-cycle pulse from the transmitter: current word fully sent.
- `busy`  out  1  frame in flight.
- `frame_done`  out  1  one-cycle pulse after the last word of a frame completes.
- `frame_cnt`  out  16  accepted-snapshot counter.
- `overrun_cnt`  out  8  dropped-snapshot counter, saturating.

## Operation
- States: IDLE, START, WAIT.
- IDLE:
  - `snap`=1 → latch `ch_data` and `ch_mask` into snapshot registers.
  - Load the header `{8'hA5, frame_cnt[RESOLUTION-9:0]}` into `word_data`. Upper header bits beyond the 16-bit counter are zero when RESOLUTION>24.
  - Increment `frame_cnt` (wraps 16'hFFFF→0).
  - Set `busy`=1 and go to START. The first frame's header carries count 0.
- START: `word_start`=1 for exactly this cycle, then WAIT.
- WAIT: hold `word_data`. On `word_done`=1:
  - If any latched-mask channel index is above the last sent index (header counts as index −1), select the lowest such index, load its latched data into `word_data`, and go to START.
  - Otherwise go to IDLE: `busy`=0, `frame_done`=1 for one cycle.
- Channel selection is a priority encoder over the latched mask; there are no idle gap cycles beyond the one-cycle START.
- Mask all zero → frame is header only.
- `word_done` in IDLE or START is ignored.
- `snap` while `busy`=1 (START, WAIT, including the cycle of the final `word_done`):
  - snapshot dropped; `overrun_cnt` += 1, saturating at 255;
  - latched data and mask are unchanged.
- Changes on `ch_data` / `ch_mask` after the latch edge do not affect the frame.
- Reset (any time, including mid-frame) forces:
  - state IDLE;
  - `word_data`=0, `word_start`=0, `busy`=0, `frame_done`=0, `frame_cnt`=0, `overrun_cnt`=0;
  - snapshot registers=0.
  
  An aborted frame is not resumed.

## Timing
- All outputs are registered.
- `snap` sampled at edge k (IDLE) → `busy`=1 and header on `word_data` after edge k; `word_start`=1 during cycle k+1 only.
- `word_done` sampled at edge m → next `word_data` after edge m; `word_start` high in cycle m+1. Per-word overhead is 1 cycle plus transmitter time.
- Final `word_done` at edge m → `busy`=0 and `frame_done`=1 in cycle m+1 only. A `snap` at edge m+1 is accepted.
- Frame length in words = 1 + popcount(latched mask).

## Test plan
- Reset, then `snap` with mask 4'b1111 and channels 32'h11111111..32'h44444444. Transmitter model returns `word_done` 20 cycles after each `word_start`. → Words A5000000, 11111111, 22222222, 33333333, 44444444 in order; exactly 5 `word_start` pulses; one `frame_done`; `frame_cnt`=1.
- Mask 4'b1010, second frame. → Header A5000001, then channel 1 data, then channel 3 data; channels 0 and 2 skipped.
- Mask 4'b0000. → Single header word, then `frame_done` one cycle after its `word_done`.
- `snap` pulsed 3 times during WAIT, plus one on the edge of the final `word_done`. → `overrun_cnt`=4; words unchanged; `ch_data` changed mid-frame has no effect; `snap` on the `frame_done` cycle is accepted.
- Spurious `word_done` in IDLE and in the START cycle. → Ignored; no state advance, no extra `word_start`.
- `rst_n` low during the third word's WAIT. → All outputs 0 asynchronously. The next `snap` produces header A5000000 and a full frame.
